sha256_digest_accumulator: RTL and testbench
============================================

# sha256_digest_accumulator

Downstream stage of the SHA-256 working-variable register bank. At the end of each 64-round compression it consumes the 256-bit packed working variables {a..h} and adds them into the stored intermediate hash H0..H7 (FIPS 180-4 step 4), using one shared 32-bit adder over 8 cycles. For intermediate blocks it hands the chaining value back to the register bank as custom initial values. For the final block it presents the digest on a valid/ready handshake, then re-arms the bank with the standard IV.

## Interface
- IV0..IV7, defaults 32'h6A09E667, BB67AE85, 3C6EF372, A54FF53A, 510E527F, 9B05688C, 1F83D9AB, 5BE0CD19: SHA-256 initial hash words.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- block_done  in  1  single-cycle pulse; work_vars holds final round values.
- first_block  in  1  sampled with block_done; addition base is IV instead of stored H.
- last_block  in  1  sampled with block_done; the result is the message digest.
- work_vars  in  256  packed {a,b,c,d,e,f,g,h}, a in [255:224].
- h_init  out  256  chaining value {H0..H7} for the register bank's custom initial-value inputs.
- load_initial  out  1  one-cycle pulse; register bank loads h_init.
- busy  out  1  high in every state except IDLE.
- digest  out  256  {H0..H7}, H0 in [255:224].
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer accepts digest.
- overrun  out  1  sticky; a block_done arrived while busy.

## Operation
- States: IDLE, ACC, LOAD, OUT.
- IDLE:
  - On block_done, capture work_vars into a 256-bit shadow, and latch last_block and first_block.
  - idx <= 0; go to ACC.
- ACC, idx 0..7, one word per cycle:
  - H[idx] <= base[idx] + W[idx] mod 2^32, carry discarded.
  - base is IV when the latched first flag is set, otherwise stored H.
  - After idx 7: go to OUT if the last flag is set, else go to LOAD.
- LOAD:
  - load_initial = 1 for exactly one cycle, with h_init = H.
  - Go to IDLE.
- OUT:
  - digest_valid = 1, and digest and H are held stable.
  - On digest_valid && digest_ready: H <= IV, digest_valid deasserts, go to LOAD. The bank is then re-armed with IV for the next message.
- block_done in ACC, LOAD or OUT (including the handshake cycle) is ignored and sets overrun.
- digest and h_init are driven directly from the H registers.

## Timing
- Reset values:
  - H = IV, so digest = h_init = IV concatenation.
  - load_initial = 0, digest_valid = 0, busy = 0, overrun = 0.
  - State IDLE, idx = 0, shadow = 0.
- Edge numbering: block_done sampled at edge 0. H0..H7 are written at edges 1..8 respectively.
- Intermediate block:
  - load_initial is high between edges 8 and 9.
  - busy is high from edge 0 through edge 9.
  - The next block_done is accepted at edge 10 or later.
- Last block:
  - digest_valid rises after edge 8.
  - Handshake at edge k: H = IV after edge k, load_initial is high between edges k and k+1, then IDLE.
- Reset asserted mid-operation: immediate return to reset values; partial H is discarded, and no load_initial or digest_valid is emitted.
- digest_ready while digest_valid is low has no effect.

## Structure
- Shared package sha256_pkg holds:
  - IV constants;
  - the state enum (IDLE/ACC/LOAD/OUT);
  - a word-width constant of 32 and a word-count constant of 8.
- Single module; no sub-module. The 32-bit adder and the 8:1 word muxes are inline.

## Test plan
- "abc" single block: block_done with first = last = 1, and work_vars = digest minus IV per word (word 0 = 506E3058) -> after edge 8, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad with digest_valid = 1.
- Wrap-around: first = 1, last = 1, word 0 = 95F61999 -> H0 = 00000000, carry dropped, other words unaffected.
- Two-block message: first block with last = 0 -> load_initial pulse after edge 8 carrying the updated H, no digest_valid. Second block with first = 0 accumulates onto that H.
- Backpressure: digest_ready low for 20 cycles -> digest_valid and digest stable throughout. Raise ready -> H = IV, one load_initial pulse with h_init = IV.
- Overrun: block_done at edge 3 of ACC, and again during an OUT handshake cycle -> both ignored, overrun = 1 and stays set, H results unchanged.
- Reset mid-ACC (after edge 4) -> all outputs return to reset values. Next block with first = 1 produces the correct digest.

Source files
------------

// File: rtl/sha256_digest_accumulator_pkg.sv
// Shared SHA-256 definitions: word geometry, initial hash value, FSM states.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WORD_CNT = 8;
  localparam int unsigned IDX_W    = $clog2(WORD_CNT);
  localparam int unsigned BLOCK_W  = WORD_W * WORD_CNT;

  typedef logic [WORD_W-1:0]                 word_t;
  // Word 0 (H0 / a) sits in the most significant slot, matching the bus layout.
  typedef logic [WORD_CNT-1:0][WORD_W-1:0]   block_t;

  localparam block_t IV = {
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    LOAD = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Map a logical word index (0 = H0) to its packed slot.
  function automatic logic [IDX_W-1:0] word_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(WORD_CNT - 1) - idx;
  endfunction

endpackage

// File: rtl/sha256_digest_accumulator_if.sv
// Bus between the round engine / digest consumer and the digest accumulator.
//   master: drives block_done, first_block, last_block, work_vars, digest_ready
//   slave : drives h_init, load_initial, busy, digest, digest_valid, overrun
interface sha256_digest_accumulator_if;
  import sha256_pkg::*;

  logic               block_done;
  logic               first_block;
  logic               last_block;
  logic [BLOCK_W-1:0] work_vars;
  logic [BLOCK_W-1:0] h_init;
  logic               load_initial;
  logic               busy;
  logic [BLOCK_W-1:0] digest;
  logic               digest_valid;
  logic               digest_ready;
  logic               overrun;

  modport master (
    output block_done, first_block, last_block, work_vars, digest_ready,
    input  h_init, load_initial, busy, digest, digest_valid, overrun
  );

  modport slave (
    input  block_done, first_block, last_block, work_vars, digest_ready,
    output h_init, load_initial, busy, digest, digest_valid, overrun
  );

endinterface

// File: rtl/sha256_digest_accumulator.sv
// SHA-256 intermediate-hash accumulator: adds the final working variables
// into H0..H7 with one shared 32-bit adder over 8 cycles, then either hands
// the chaining value back to the register bank or presents the digest.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of sha256_digest_accumulator_if
module sha256_digest_accumulator
  import sha256_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  sha256_digest_accumulator_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  block_t           r_h;
  block_t           r_shadow;
  logic             r_first;
  logic             r_last;
  logic             r_load_initial;
  logic             r_digest_valid;
  logic             r_busy;
  logic             r_overrun;

  logic             w_accept;
  logic             w_handshake;
  logic [IDX_W-1:0] w_pos;
  word_t            w_base;
  word_t            w_sum;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic and the shared word adder
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    w_pos       = word_pos(r_idx);
    w_base      = r_first ? IV[w_pos] : r_h[w_pos];
    w_sum       = w_base + r_shadow[w_pos];
    case (r_state)
      IDLE: begin
        if (bus.block_done) begin
          w_accept    = 1'b1;
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        if (r_idx == IDX_W'(WORD_CNT - 1)) w_state_nxt = r_last ? OUT : LOAD;
      end
      LOAD: w_state_nxt = IDLE;
      OUT: begin
        if (bus.digest_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath, flags and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx          <= '0;
      r_h            <= IV;
      r_shadow       <= '0;
      r_first        <= 1'b0;
      r_last         <= 1'b0;
      r_load_initial <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow <= bus.work_vars;
        r_first  <= bus.first_block;
        r_last   <= bus.last_block;
        r_idx    <= '0;
      end
      if (r_state == ACC) begin
        r_h[w_pos] <= w_sum;
        r_idx      <= r_idx + IDX_W'(1);
      end
      // Re-arm with IV once the digest has been taken.
      if (w_handshake) r_h <= IV;
      if (bus.block_done && (r_state != IDLE)) r_overrun <= 1'b1;
      r_load_initial <= (w_state_nxt == LOAD);
      r_digest_valid <= (w_state_nxt == OUT);
      r_busy         <= (w_state_nxt != IDLE);
    end
  end

  assign bus.h_init       = r_h;
  assign bus.digest       = r_h;
  assign bus.load_initial = r_load_initial;
  assign bus.digest_valid = r_digest_valid;
  assign bus.busy         = r_busy;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_sha256_digest_accumulator.sv
// Directed bench for sha256_digest_accumulator: single-block vector table
// plus hand-written two-block, backpressure, overrun and reset sequences.
module tb_sha256_digest_accumulator;

  localparam logic [255:0] IV_EXP  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_EXP = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] WRAP_WV = 256'h95f61999_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] WRAP_EXP = 256'h00000000_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ONES_WV = {8{32'hffffffff}};
  localparam logic [255:0] IVM1_EXP = 256'h6a09e666_bb67ae84_3c6ef371_a54ff539_510e527e_9b05688b_1f83d9aa_5be0cd18;
  localparam logic [255:0] PLUS1_WV = {8{32'h00000001}};
  localparam logic [255:0] ABC_P1_EXP = 256'hba7816c0_8f01cfeb_414140df_5dae2224_b00361a4_96177a9d_b410ff62_f20015ae;
  localparam logic [255:0] JUNK_WV = {8{32'hdeadbeef}};

  typedef struct {
    logic         first;
    logic [255:0] wv;
    logic [255:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [255:0] abc_wv;
  vec_t vecs [5];

  sha256_digest_accumulator_if bus();

  sha256_digest_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // Per-word modular difference, used to build work_vars from a known digest.
  function automatic logic [255:0] sub_words(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse block_done across exactly one rising edge (edge 0).
  task automatic drive_block(input logic f, input logic l, input logic [255:0] wv);
    bus.first_block = f;
    bus.last_block  = l;
    bus.work_vars   = wv;
    bus.block_done  = 1'b1;
    tick();
    bus.block_done  = 1'b0;
    bus.first_block = 1'b0;
    bus.last_block  = 1'b0;
  endtask

  // Called just after the edge where digest_valid rose; completes handshake.
  task automatic accept_digest(input string tag);
    bus.digest_ready = 1'b1;
    tick();
    bus.digest_ready = 1'b0;
    chk({tag, " H=IV after handshake"}, bus.digest, IV_EXP);
    chk({tag, " h_init=IV"}, bus.h_init, IV_EXP);
    chk({tag, " load_initial pulse"}, 256'(bus.load_initial), 256'(1'b1));
    chk({tag, " valid dropped"}, 256'(bus.digest_valid), 256'(1'b0));
    tick();
    chk({tag, " load_initial ended"}, 256'(bus.load_initial), 256'(1'b0));
    chk({tag, " busy low"}, 256'(bus.busy), 256'(1'b0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    abc_wv = sub_words(ABC_EXP, IV_EXP);
    vecs[0] = '{first: 1'b1, wv: abc_wv,       exp: ABC_EXP};
    vecs[1] = '{first: 1'b1, wv: WRAP_WV,      exp: WRAP_EXP};
    vecs[2] = '{first: 1'b1, wv: ONES_WV,      exp: IVM1_EXP};
    vecs[3] = '{first: 1'b0, wv: ONES_WV,      exp: IVM1_EXP};
    vecs[4] = '{first: 1'b0, wv: 256'h0,       exp: IV_EXP};

    bus.block_done   = 1'b0;
    bus.first_block  = 1'b0;
    bus.last_block   = 1'b0;
    bus.work_vars    = '0;
    bus.digest_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("reset digest", bus.digest, IV_EXP);
    chk("reset h_init", bus.h_init, IV_EXP);
    chk("reset load_initial", 256'(bus.load_initial), 256'(1'b0));
    chk("reset digest_valid", 256'(bus.digest_valid), 256'(1'b0));
    chk("reset busy", 256'(bus.busy), 256'(1'b0));
    chk("reset overrun", 256'(bus.overrun), 256'(1'b0));
    rst = 1'b1;
    tick();

    // Single-block table
    if (abc_wv[255:224] !== 32'h506e3058) begin
      n_err++;
      $display("FAIL abc word0 setup: got %h required 506e3058", abc_wv[255:224]);
    end
    for (int v = 0; v < 5; v++) begin
      string t;
      t = $sformatf("vec%0d", v);
      drive_block(vecs[v].first, 1'b1, vecs[v].wv);
      chk({t, " busy after edge0"}, 256'(bus.busy), 256'(1'b1));
      repeat (7) tick();
      chk({t, " no valid after edge7"}, 256'(bus.digest_valid), 256'(1'b0));
      tick();
      chk({t, " valid after edge8"}, 256'(bus.digest_valid), 256'(1'b1));
      chk({t, " digest"}, bus.digest, vecs[v].exp);
      chk({t, " no load_initial in OUT"}, 256'(bus.load_initial), 256'(1'b0));
      accept_digest(t);
    end
    chk("no overrun yet", 256'(bus.overrun), 256'(1'b0));

    // Two-block message with backpressure on the final digest
    drive_block(1'b1, 1'b0, abc_wv);
    repeat (7) tick();
    chk("blk1 load before edge8", 256'(bus.load_initial), 256'(1'b0));
    tick();
    chk("blk1 load_initial", 256'(bus.load_initial), 256'(1'b1));
    chk("blk1 h_init", bus.h_init, ABC_EXP);
    chk("blk1 no valid", 256'(bus.digest_valid), 256'(1'b0));
    chk("blk1 busy in LOAD", 256'(bus.busy), 256'(1'b1));
    tick();
    chk("blk1 load ended", 256'(bus.load_initial), 256'(1'b0));
    chk("blk1 busy low", 256'(bus.busy), 256'(1'b0));
    bus.digest_ready = 1'b1;
    tick();
    bus.digest_ready = 1'b0;
    chk("idle ready ignored h", bus.h_init, ABC_EXP);
    chk("idle ready no load", 256'(bus.load_initial), 256'(1'b0));
    drive_block(1'b0, 1'b1, PLUS1_WV);
    repeat (8) tick();
    chk("blk2 valid", 256'(bus.digest_valid), 256'(1'b1));
    chk("blk2 digest", bus.digest, ABC_P1_EXP);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("bp%0d valid", c), 256'(bus.digest_valid), 256'(1'b1));
      chk($sformatf("bp%0d digest", c), bus.digest, ABC_P1_EXP);
    end
    accept_digest("bp");

    // Overrun: during ACC and during the OUT handshake cycle
    drive_block(1'b1, 1'b1, abc_wv);
    repeat (2) tick();
    drive_block(1'b0, 1'b0, JUNK_WV);
    chk("overrun after ACC pulse", 256'(bus.overrun), 256'(1'b1));
    repeat (5) tick();
    chk("ovr digest", bus.digest, ABC_EXP);
    chk("ovr valid", 256'(bus.digest_valid), 256'(1'b1));
    bus.block_done   = 1'b1;
    bus.first_block  = 1'b1;
    bus.last_block   = 1'b1;
    bus.work_vars    = JUNK_WV;
    bus.digest_ready = 1'b1;
    tick();
    bus.block_done   = 1'b0;
    bus.first_block  = 1'b0;
    bus.last_block   = 1'b0;
    bus.digest_ready = 1'b0;
    chk("ovr hs H=IV", bus.digest, IV_EXP);
    chk("ovr hs load", 256'(bus.load_initial), 256'(1'b1));
    tick();
    chk("ovr back idle", 256'(bus.busy), 256'(1'b0));
    tick();
    chk("ovr junk not taken", 256'(bus.busy), 256'(1'b0));
    chk("overrun sticky", 256'(bus.overrun), 256'(1'b1));

    // Reset mid-ACC, then a clean block
    drive_block(1'b1, 1'b0, abc_wv);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("rst digest", bus.digest, IV_EXP);
    chk("rst busy", 256'(bus.busy), 256'(1'b0));
    chk("rst overrun", 256'(bus.overrun), 256'(1'b0));
    chk("rst load", 256'(bus.load_initial), 256'(1'b0));
    chk("rst valid", 256'(bus.digest_valid), 256'(1'b0));
    tick();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("post-rst%0d quiet", c), 256'({bus.load_initial, bus.digest_valid, bus.busy}), 256'(3'b000));
    end
    chk("post-rst H", bus.h_init, IV_EXP);
    drive_block(1'b1, 1'b1, abc_wv);
    repeat (8) tick();
    chk("post-rst valid", 256'(bus.digest_valid), 256'(1'b1));
    chk("post-rst digest", bus.digest, ABC_EXP);
    accept_digest("post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
